// File: rtl/seg7_pkg.sv
// Shared types and segment code constants for the seven-segment reader and
// any loop-back checker that decodes segment patterns.
package seg7_pkg;

    typedef enum logic [2:0] {
        VER_RCA     = 3'd0,
        VER_TI      = 3'd1,
        VER_NSC     = 3'd2,
        VER_TOSHIBA = 3'd3,
        VER_LINES   = 3'd4,
        VER_ELEK    = 3'd5,
        VER_CODEB   = 3'd6,
        VER_HEX     = 3'd7
    } seg7_ver_e;

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_LOCKED  = 1'b1
    } filt_state_e;

    // Patterns are {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [6:0] SEG_0      = 7'h3F;
    localparam logic [6:0] SEG_1      = 7'h06;
    localparam logic [6:0] SEG_2      = 7'h5B;
    localparam logic [6:0] SEG_3      = 7'h4F;
    localparam logic [6:0] SEG_4      = 7'h66;
    localparam logic [6:0] SEG_5      = 7'h6D;
    localparam logic [6:0] SEG_6      = 7'h7D;
    localparam logic [6:0] SEG_6_ALT  = 7'h7C;
    localparam logic [6:0] SEG_7      = 7'h27;
    localparam logic [6:0] SEG_7_ALT  = 7'h07;
    localparam logic [6:0] SEG_8      = 7'h7F;
    localparam logic [6:0] SEG_9      = 7'h6F;
    localparam logic [6:0] SEG_9_ALT  = 7'h67;

    localparam logic [6:0] SEG_TI_10  = 7'h58;
    localparam logic [6:0] SEG_TI_11  = 7'h4C;
    localparam logic [6:0] SEG_TI_12  = 7'h62;
    localparam logic [6:0] SEG_TI_13  = 7'h69;
    localparam logic [6:0] SEG_TI_14  = 7'h78;

    localparam logic [6:0] SEG_NSC_10 = 7'h5C;
    localparam logic [6:0] SEG_NSC_11 = 7'h63;
    localparam logic [6:0] SEG_NSC_12 = 7'h01;
    localparam logic [6:0] SEG_NSC_13 = 7'h40;
    localparam logic [6:0] SEG_NSC_14 = 7'h08;

    localparam logic [6:0] SEG_LIN_10 = 7'h08;
    localparam logic [6:0] SEG_LIN_11 = 7'h48;
    localparam logic [6:0] SEG_LIN_12 = 7'h49;
    localparam logic [6:0] SEG_LIN_13 = 7'h41;
    localparam logic [6:0] SEG_LIN_14 = 7'h01;

    localparam logic [6:0] SEG_ELK_10 = 7'h40;
    localparam logic [6:0] SEG_ELK_11 = 7'h38;
    localparam logic [6:0] SEG_ELK_12 = 7'h39;
    localparam logic [6:0] SEG_ELK_13 = 7'h31;
    localparam logic [6:0] SEG_ELK_14 = 7'h79;

    localparam logic [6:0] SEG_CDB_10 = 7'h40;
    localparam logic [6:0] SEG_CDB_11 = 7'h79;
    localparam logic [6:0] SEG_CDB_12 = 7'h76;
    localparam logic [6:0] SEG_CDB_13 = 7'h38;
    localparam logic [6:0] SEG_CDB_14 = 7'h73;

    localparam logic [6:0] SEG_HEX_A  = 7'h77;
    localparam logic [6:0] SEG_HEX_B  = 7'h7C;
    localparam logic [6:0] SEG_HEX_C  = 7'h39;
    localparam logic [6:0] SEG_HEX_D  = 7'h5E;
    localparam logic [6:0] SEG_HEX_E  = 7'h79;
    localparam logic [6:0] SEG_HEX_F  = 7'h71;

    function automatic int seg7_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from (segment pattern, code version) to a 4-bit value
// with blank/illegal flags. Version-specific codes win over plain digits.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    input  seg7_ver_e  version_i,
    output logic [3:0] value_o,
    output logic       blank_o,
    output logic       err_o
);

    logic       ext_hit;
    logic [3:0] ext_val;

    always_comb begin
        ext_hit = 1'b1;
        ext_val = 4'd0;
        case (version_i)
            VER_TI: begin
                case (pattern_i)
                    SEG_TI_10: ext_val = 4'd10;
                    SEG_TI_11: ext_val = 4'd11;
                    SEG_TI_12: ext_val = 4'd12;
                    SEG_TI_13: ext_val = 4'd13;
                    SEG_TI_14: ext_val = 4'd14;
                    default:   ext_hit = 1'b0;
                endcase
            end
            VER_NSC: begin
                case (pattern_i)
                    SEG_NSC_10: ext_val = 4'd10;
                    SEG_NSC_11: ext_val = 4'd11;
                    SEG_NSC_12: ext_val = 4'd12;
                    SEG_NSC_13: ext_val = 4'd13;
                    SEG_NSC_14: ext_val = 4'd14;
                    default:    ext_hit = 1'b0;
                endcase
            end
            VER_LINES: begin
                case (pattern_i)
                    SEG_LIN_10: ext_val = 4'd10;
                    SEG_LIN_11: ext_val = 4'd11;
                    SEG_LIN_12: ext_val = 4'd12;
                    SEG_LIN_13: ext_val = 4'd13;
                    SEG_LIN_14: ext_val = 4'd14;
                    default:    ext_hit = 1'b0;
                endcase
            end
            VER_ELEK: begin
                case (pattern_i)
                    SEG_ELK_10: ext_val = 4'd10;
                    SEG_ELK_11: ext_val = 4'd11;
                    SEG_ELK_12: ext_val = 4'd12;
                    SEG_ELK_13: ext_val = 4'd13;
                    SEG_ELK_14: ext_val = 4'd14;
                    default:    ext_hit = 1'b0;
                endcase
            end
            VER_CODEB: begin
                case (pattern_i)
                    SEG_CDB_10: ext_val = 4'd10;
                    SEG_CDB_11: ext_val = 4'd11;
                    SEG_CDB_12: ext_val = 4'd12;
                    SEG_CDB_13: ext_val = 4'd13;
                    SEG_CDB_14: ext_val = 4'd14;
                    default:    ext_hit = 1'b0;
                endcase
            end
            VER_HEX: begin
                case (pattern_i)
                    SEG_HEX_A: ext_val = 4'd10;
                    SEG_HEX_B: ext_val = 4'd11;
                    SEG_HEX_C: ext_val = 4'd12;
                    SEG_HEX_D: ext_val = 4'd13;
                    SEG_HEX_E: ext_val = 4'd14;
                    SEG_HEX_F: ext_val = 4'd15;
                    default:   ext_hit = 1'b0;
                endcase
            end
            // RCA and Toshiba fall through to the plain digit table.
            default: ext_hit = 1'b0;
        endcase
    end

    always_comb begin
        value_o = 4'd0;
        blank_o = 1'b0;
        err_o   = 1'b0;
        if (ext_hit) begin
            value_o = ext_val;
        end else begin
            case (pattern_i)
                SEG_0:            value_o = 4'd0;
                SEG_1:            value_o = 4'd1;
                SEG_2:            value_o = 4'd2;
                SEG_3:            value_o = 4'd3;
                SEG_4:            value_o = 4'd4;
                SEG_5:            value_o = 4'd5;
                SEG_6, SEG_6_ALT: value_o = 4'd6;
                SEG_7, SEG_7_ALT: value_o = 4'd7;
                SEG_8:            value_o = 4'd8;
                SEG_9, SEG_9_ALT: value_o = 4'd9;
                SEG_BLANK:        blank_o = 1'b1;
                default:          err_o   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a seven-segment display back into a 4-bit value: synchronise, filter
// for stability, decode, and hand over changed readings via valid/ready.
//
// state      | meaning
// ST_ACQUIRE | counting consecutive identical samples of the pattern
// ST_LOCKED  | pattern accepted, waiting for the next pattern/version change
module seven_segment_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic V0,
    input  logic V1,
    input  logic V2,
    input  logic AL,
    input  logic Sa,
    input  logic Sb,
    input  logic Sc,
    input  logic Sd,
    input  logic Se,
    input  logic Sf,
    input  logic Sg,
    input  logic READY,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic BLANK,
    output logic ERR,
    output logic VALID,
    output logic OVR
);

    localparam int                CNT_W    = seg7_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]  pat_raw;
    seg7_ver_e   ver;

    logic [6:0]  sync1_q, sync2_q, s_prev_q;
    seg7_ver_e   ver_prev_q;
    logic        changed;

    filt_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock;

    logic [6:0]  cand_pat_q;
    seg7_ver_e   cand_ver_q;
    logic        cand_new_q;

    logic [6:0]  last_pat_q;
    seg7_ver_e   last_ver_q;
    logic        last_vld_q;
    logic        report;

    logic [3:0]  dec_val;
    logic        dec_blank, dec_err;

    logic [3:0]  val_q, val_d;
    logic        blank_q, blank_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;

    // Polarity is normalised before the synchroniser so s is always lit-high.
    assign pat_raw = {Sg, Sf, Se, Sd, Sc, Sb, Sa} ^ {7{~AL}};
    assign ver     = seg7_ver_e'({V2, V1, V0});
    assign changed = (sync2_q != s_prev_q) || (ver != ver_prev_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q    <= 7'd0;
            sync2_q    <= 7'd0;
            s_prev_q   <= 7'd0;
            ver_prev_q <= VER_RCA;
        end else begin
            sync1_q    <= pat_raw;
            sync2_q    <= sync1_q;
            s_prev_q   <= sync2_q;
            ver_prev_q <= ver;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock    = 1'b0;
        case (state_q)
            ST_ACQUIRE: begin
                if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                    lock    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (changed) begin
                    state_d = ST_ACQUIRE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_ACQUIRE;
            cnt_q      <= '0;
            cand_pat_q <= 7'd0;
            cand_ver_q <= VER_RCA;
            cand_new_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_new_q <= lock;
            if (lock) begin
                cand_pat_q <= sync2_q;
                cand_ver_q <= ver;
            end
        end
    end

    seg7_pattern_decode u_decode (
        .pattern_i (cand_pat_q),
        .version_i (cand_ver_q),
        .value_o   (dec_val),
        .blank_o   (dec_blank),
        .err_o     (dec_err)
    );

    // Only readings that differ from the last delivered (pattern, version) go out.
    assign report = cand_new_q &&
                    (!last_vld_q || (cand_pat_q != last_pat_q) || (cand_ver_q != last_ver_q));

    always_comb begin
        val_d   = val_q;
        blank_d = blank_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && READY) begin
            valid_d = 1'b0;
        end
        if (report) begin
            val_d   = dec_val;
            blank_d = dec_blank;
            err_d   = dec_err;
            valid_d = 1'b1;
            ovr_d   = valid_q && !READY;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_pat_q <= 7'd0;
            last_ver_q <= VER_RCA;
            last_vld_q <= 1'b0;
            val_q      <= 4'd0;
            blank_q    <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (report) begin
                last_pat_q <= cand_pat_q;
                last_ver_q <= cand_ver_q;
                last_vld_q <= 1'b1;
            end
            val_q   <= val_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign A     = val_q[0];
    assign B     = val_q[1];
    assign C     = val_q[2];
    assign D     = val_q[3];
    assign BLANK = blank_q;
    assign ERR   = err_q;
    assign VALID = valid_q;
    assign OVR   = ovr_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: a vector table of held patterns
// plus hand-written glitch, overwrite and mid-operation reset sequences.
module tb_seven_segment_reader;

    logic CLK = 1'b0;
    logic RST_N;
    logic V0, V1, V2, AL;
    logic Sa, Sb, Sc, Sd, Se, Sf, Sg;
    logic READY;
    logic A, B, C, D, BLANK, ERR, VALID, OVR;

    int n_pass = 0;
    int n_total = 0;

    seven_segment_reader #(.STABLE_CYCLES(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .V0    (V0),
        .V1    (V1),
        .V2    (V2),
        .AL    (AL),
        .Sa    (Sa),
        .Sb    (Sb),
        .Sc    (Sc),
        .Sd    (Sd),
        .Se    (Se),
        .Sf    (Sf),
        .Sg    (Sg),
        .READY (READY),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .BLANK (BLANK),
        .ERR   (ERR),
        .VALID (VALID),
        .OVR   (OVR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] ver;
        logic       al;
        logic [6:0] pat;
        int         lat;
        logic [3:0] val;
        logic       blank;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input logic [2:0] ver, input logic al, input logic [6:0] pat);
        logic [6:0] lines;
        lines = pat ^ {7{~al}};
        {V2, V1, V0} = ver;
        AL = al;
        {Sg, Sf, Se, Sd, Sc, Sb, Sa} = lines;
    endtask

    // Edges from now until VALID is seen at a falling edge; 40 means never.
    task automatic wait_valid(output int k);
        k = 40;
        for (int e = 0; e < 40; e++) begin
            @(negedge CLK);
            if (VALID) begin
                k = e;
                break;
            end
        end
    endtask

    task automatic handshake();
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
    endtask

    function automatic int value();
        return int'({D, C, B, A});
    endfunction

    initial begin
        int k;
        int seen;
        int ovr_cnt;

        vecs[0]  = '{3'd7, 1'b1, 7'h7C, 7, 4'd11, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 1'b1, 7'h7C, 5, 4'd6,  1'b0, 1'b0};
        vecs[2]  = '{3'd3, 1'b1, 7'h4F, 7, 4'd3,  1'b0, 1'b0};
        vecs[3]  = '{3'd1, 1'b1, 7'h7E, 7, 4'd0,  1'b0, 1'b1};
        vecs[4]  = '{3'd4, 1'b1, 7'h49, 7, 4'd12, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 1'b1, 7'h79, 7, 4'd14, 1'b0, 1'b0};
        vecs[6]  = '{3'd6, 1'b1, 7'h40, 7, 4'd10, 1'b0, 1'b0};
        vecs[7]  = '{3'd2, 1'b0, 7'h01, 7, 4'd12, 1'b0, 1'b0};
        vecs[8]  = '{3'd3, 1'b1, 7'h6D, 7, 4'd5,  1'b0, 1'b0};
        vecs[9]  = '{3'd7, 1'b1, 7'h71, 7, 4'd15, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 1'b1, 7'h67, 7, 4'd9,  1'b0, 1'b0};
        vecs[11] = '{3'd0, 1'b1, 7'h58, 7, 4'd0,  1'b0, 1'b1};
        vecs[12] = '{3'd5, 1'b1, 7'h07, 7, 4'd7,  1'b0, 1'b0};
        vecs[13] = '{3'd0, 1'b0, 7'h00, 7, 4'd0,  1'b1, 1'b0};

        RST_N = 1'b0;
        READY = 1'b0;
        apply(vecs[0].ver, vecs[0].al, vecs[0].pat);
        repeat (3) @(negedge CLK);
        chk("reset_valid", VALID, 0);
        chk("reset_value", value(), 0);
        chk("reset_blank", BLANK, 0);
        chk("reset_err", ERR, 0);
        chk("reset_ovr", OVR, 0);
        RST_N = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].ver, vecs[i].al, vecs[i].pat);
            wait_valid(k);
            chk($sformatf("v%0d_latency", i), k, vecs[i].lat);
            chk($sformatf("v%0d_value", i), value(), vecs[i].val);
            chk($sformatf("v%0d_blank", i), BLANK, vecs[i].blank);
            chk($sformatf("v%0d_err", i), ERR, vecs[i].err);
            chk($sformatf("v%0d_ovr", i), OVR, 0);
            handshake();
            chk($sformatf("v%0d_valid_cleared", i), VALID, 0);
        end

        // Blank held after its handshake must not be reported again.
        seen = 0;
        repeat (15) begin
            @(negedge CLK);
            if (VALID) seen++;
        end
        chk("blank_no_rereport", seen, 0);

        // Short glitch to 06 between steady 5B.
        apply(3'd2, 1'b1, 7'h5B);
        wait_valid(k);
        chk("glitch_base_latency", k, 7);
        chk("glitch_base_value", value(), 2);
        handshake();
        apply(3'd2, 1'b1, 7'h06);
        repeat (3) @(negedge CLK);
        apply(3'd2, 1'b1, 7'h5B);
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (VALID) seen++;
        end
        chk("glitch_no_report", seen, 0);

        // Overwrite of an unconsumed report.
        apply(3'd2, 1'b1, 7'h06);
        wait_valid(k);
        chk("ovr_first_value", value(), 1);
        apply(3'd2, 1'b1, 7'h66);
        ovr_cnt = 0;
        repeat (15) begin
            @(negedge CLK);
            if (OVR) ovr_cnt++;
        end
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_valid_held", VALID, 1);
        chk("ovr_value", value(), 4);

        // Asynchronous reset while a report is pending.
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_valid", VALID, 0);
        chk("midrst_value", value(), 0);
        chk("midrst_flags", int'({BLANK, ERR, OVR}), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_valid(k);
        chk("midrst_relock_latency", k, 7);
        chk("midrst_relock_value", value(), 4);
        handshake();
        chk("midrst_valid_cleared", VALID, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
